// File: rtl/sample_mixer_pkg.sv
// Shared types and helpers for the sample_mixer playback engine.
// Holds the voice state enum, the clog2 helper, the mix-width constant and the saturator.
package sample_mixer_pkg;

  typedef enum logic {
    V_IDLE = 1'b0,
    V_PLAY = 1'b1
  } voice_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int NUM_VOICES_DEF = 4;
  localparam int DATA_W_DEF     = 8;
  // Sum width that can never wrap: one sample width plus one bit per voice doubling.
  localparam int MIX_W          = DATA_W_DEF + clog2(NUM_VOICES_DEF);

  // Clamp a signed value to the range of a signed width-bit word.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                  input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/sample_voice.sv
// One playback voice: IDLE/PLAY state machine, sample position counter and the
// registered ROM fetch address for the sample played on the latest tick.
module sample_voice
  import sample_mixer_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int SAMPLE_LEN = 8192
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick,
  input  logic              trig,
  output logic              active,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(SAMPLE_LEN - 1);

  voice_state_t      state;
  voice_state_t      state_next;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] pos_next;
  logic [ADDR_W-1:0] addr_next;

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= V_IDLE;
      pos   <= '0;
      addr  <= '0;
    end else begin
      state <= state_next;
      pos   <= pos_next;
      addr  <= addr_next;
    end
  end

  // pos is the next sample to play; addr latches it on a tick so the mixer sees
  // the sample belonging to that tick, including the last one before IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_next = state;
    pos_next   = pos;
    addr_next  = addr;
    if (trig) begin
      state_next = V_PLAY;
      pos_next   = '0;
      addr_next  = '0;
    end else if (state == V_PLAY && tick) begin
      addr_next = pos;
      if (pos == LAST_POS) begin
        state_next = V_IDLE;
        pos_next   = '0;
      end else begin
        pos_next = pos + 1'b1;
      end
    end
  end

  assign active = (state == V_PLAY);

endmodule

// File: rtl/sample_mixer.sv
// Polyphonic sample playback: NUM_VOICES voices, 3-cycle tick-to-out mix pipeline.
// Optional per-voice shift gain when SAMPLE_MIXER_GAIN_EN is defined.
module sample_mixer
  import sample_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_LEN = 8192
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           tick,
  input  logic [NUM_VOICES-1:0]          trig,
  input  logic [NUM_VOICES-1:0]          mute,
  output logic [NUM_VOICES*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_VOICES*DATA_W-1:0]   rom_q,
`ifdef SAMPLE_MIXER_GAIN_EN
  input  logic [2*NUM_VOICES-1:0]        gain,
`endif
  output logic [NUM_VOICES-1:0]          active,
  output logic signed [DATA_W-1:0]       out,
  output logic                           out_valid
);

  localparam int SUM_W = DATA_W + clog2(NUM_VOICES);

  logic                    tick_d1;
  logic                    tick_d2;
  logic [NUM_VOICES-1:0]   act_d1;
  logic [NUM_VOICES-1:0]   act_d2;
  logic signed [SUM_W-1:0] mix_sum;
  logic signed [DATA_W-1:0] voice_sample;
  logic [1:0]              voice_shift;
  logic signed [DATA_W-1:0] mix_sat;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    sample_voice #(
      .ADDR_W    (ADDR_W),
      .SAMPLE_LEN(SAMPLE_LEN)
    ) u_voice (
      .clk   (clk),
      .resetn(resetn),
      .tick  (tick),
      .trig  (trig[v]),
      .active(active[v]),
      .addr  (rom_addr[v*ADDR_W +: ADDR_W])
    );
  end

  // The active mask is captured before the tick takes effect, so a voice that
  // ends on this tick still contributes its final sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_d1 <= 1'b0;
      tick_d2 <= 1'b0;
      act_d1  <= '0;
      act_d2  <= '0;
    end else begin
      tick_d1 <= tick;
      tick_d2 <= tick_d1;
      act_d1  <= tick ? active : '0;
      act_d2  <= act_d1;
    end
  end

  always_comb begin
    mix_sum      = '0;
    voice_sample = '0;
    voice_shift  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_sample = rom_q[v*DATA_W +: DATA_W];
`ifdef SAMPLE_MIXER_GAIN_EN
      voice_shift = gain[2*v +: 2];
`else
      voice_shift = 2'd0;
`endif
      if (act_d2[v] && !mute[v]) begin
        mix_sum = mix_sum + SUM_W'(voice_sample >>> voice_shift);
      end
    end
  end

  assign mix_sat = DATA_W'(saturate(32'(mix_sum), DATA_W));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= tick_d2;
      if (tick_d2) out <= mix_sat;
    end
  end

endmodule

// File: tb/tb_sample_mixer.sv
// Self-checking bench for sample_mixer: directed vector table, hand sequences and
// randomized traffic against a tick-level behavioural model with a timestamped queue.
module tb_sample_mixer;

  localparam int NV  = 4;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LEN = 8;
  localparam int LW  = 3;
  localparam int MAXV = 127;
  localparam int MINV = -128;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  tick;
  logic [NV-1:0]         trig;
  logic [NV-1:0]         mute;
  logic [NV*AW-1:0]      rom_addr;
  logic [NV*DW-1:0]      rom_q;
  logic [NV-1:0]         active;
  logic signed [DW-1:0]  out;
  logic                  out_valid;
`ifdef SAMPLE_MIXER_GAIN_EN
  logic [2*NV-1:0]       gain;
`endif

  always #5 clk = ~clk;

  sample_mixer #(
    .NUM_VOICES(NV),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .SAMPLE_LEN(LEN)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tick     (tick),
    .trig     (trig),
    .mute     (mute),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
`ifdef SAMPLE_MIXER_GAIN_EN
    .gain     (gain),
`endif
    .active   (active),
    .out      (out),
    .out_valid(out_valid)
  );

  // External sample ROMs, one-cycle read latency.
  logic signed [DW-1:0] rom [NV][LEN];
  always @(posedge clk) begin
    for (int v = 0; v < NV; v++) rom_q[v*DW +: DW] <= rom[v][rom_addr[v*AW +: LW]];
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: per voice a playing flag and the position of the next sample.
  typedef struct { int due; int val; } exp_t;
  exp_t                 exp_q[$];
  logic [NV-1:0]        m_play;
  int                   m_pos [NV];
  logic signed [31:0]   last_out;
  bit                   mon_en = 1'b0;

  function automatic int gain_of(input int v);
`ifdef SAMPLE_MIXER_GAIN_EN
    return int'(gain[2*v +: 2]);
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("out_valid_pulse", out_valid, 1);
        check("out_value", out, exp_q[0].val);
        last_out = exp_q[0].val;
        void'(exp_q.pop_front());
      end else begin
        check("out_valid_idle", out_valid, 0);
        check("out_hold", out, last_out);
      end
    end
  end

  // One clock cycle of stimulus; the model advances at tick/trig granularity.
  task automatic cycle(input logic t, input logic [NV-1:0] tr);
    int sum;
    if (t) begin
      sum = 0;
      for (int v = 0; v < NV; v++)
        if (m_play[v] && !mute[v]) sum += int'(rom[v][m_pos[v]]) >>> gain_of(v);
      if (sum > MAXV) sum = MAXV;
      else if (sum < MINV) sum = MINV;
      exp_q.push_back('{due: cyc + 3, val: sum});
      for (int v = 0; v < NV; v++) begin
        if (m_play[v]) begin
          if (m_pos[v] == LEN - 1) begin
            m_play[v] = 1'b0;
            m_pos[v]  = 0;
          end else begin
            m_pos[v]++;
          end
        end
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (tr[v]) begin
        m_play[v] = 1'b1;
        m_pos[v]  = 0;
      end
    end
    tick = t;
    trig = tr;
    @(posedge clk);
    #1;
    tick = 1'b0;
    trig = '0;
    check("active", active, m_play);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  // Asynchronous reset with immediate checks of the cleared outputs.
  task automatic do_reset();
    resetn = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    last_out = 0;
    m_play   = '0;
    for (int v = 0; v < NV; v++) m_pos[v] = 0;
    #1;
    check("rst_active", active, 0);
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rom_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic fill_voice(input int v, input int value);
    for (int a = 0; a < LEN; a++) rom[v][a] = DW'(value);
  endtask

  typedef struct {
    int            val [NV];
    logic [NV-1:0] voices;
    logic [NV-1:0] mute;
    int            expv;
  } vec_t;
  vec_t vecs [12];

  task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                         input logic [NV-1:0] voices, input logic [NV-1:0] mt, input int expv);
    vecs[i].val[0] = a;
    vecs[i].val[1] = b;
    vecs[i].val[2] = c;
    vecs[i].val[3] = d;
    vecs[i].voices = voices;
    vecs[i].mute   = mt;
    vecs[i].expv   = expv;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d expected < 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_vec(0,  100,  100,  100,  100, 4'b1111, 4'b0000,  127);
    set_vec(1, -100, -100, -100, -100, 4'b1111, 4'b0000, -128);
    set_vec(2,  100,  -30,    0,    0, 4'b0011, 4'b0000,   70);
    set_vec(3,   50,   77,    0,    0, 4'b0011, 4'b0010,   50);
    set_vec(4,  127,  127,  127,  127, 4'b1111, 4'b0000,  127);
    set_vec(5, -128, -128, -128, -128, 4'b1111, 4'b0000, -128);
    set_vec(6,   10,   20,   30,   40, 4'b0101, 4'b0000,   40);
    set_vec(7,   -1,   -1,   -1,   -1, 4'b1111, 4'b0000,   -4);
    set_vec(8,  127,    1,    0,    0, 4'b0011, 4'b0000,  127);
    set_vec(9, -128,   -1,    0,    0, 4'b0011, 4'b0000, -128);
    set_vec(10, 127, -128,    0,    0, 4'b0011, 4'b0000,   -1);
    set_vec(11,   5,    5,    5,    5, 4'b1111, 4'b1111,    0);

    resetn = 1'b1;
    tick   = 1'b0;
    trig   = '0;
    mute   = '0;
`ifdef SAMPLE_MIXER_GAIN_EN
    gain   = '0;
`endif
    for (int v = 0; v < NV; v++)
      for (int a = 0; a < LEN; a++) rom[v][a] = DW'($urandom);
    for (int a = 0; a < LEN; a++) rom[0][a] = DW'(a);
    #1;
    do_reset();

    // No voices triggered: silence, with out_valid following every tick.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, '0);
      if (i < 5) idle(1);
    end
    idle(4);

    // Voice 0 plays ROM0[a]=a through to the end, then falls silent.
    cycle(1'b0, 4'b0001);
    check("trig_rom_addr0", rom_addr[AW-1:0], 0);
    for (int i = 0; i < LEN; i++) begin
      cycle(1'b1, '0);
      if (i % 3 == 0) idle(1);
    end
    check("end_active0", active[0], 0);
    cycle(1'b1, '0);
    idle(4);

    // Retrigger at position 5 restarts from sample 0.
    do_reset();
    cycle(1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) cycle(1'b1, '0);
    idle(1);
    cycle(1'b0, 4'b0001);
    check("retrig_rom_addr0", rom_addr[AW-1:0], 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, '0);
    idle(4);

    // Vector table: mix arithmetic, saturation limits and muting.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      mute = vecs[i].mute;
      for (int v = 0; v < NV; v++) fill_voice(v, vecs[i].val[v]);
      cycle(1'b0, vecs[i].voices);
      cycle(1'b1, '0);
      idle(2);
      check("vec_out_valid", out_valid, 1);
      check("vec_out", out, vecs[i].expv);
      check("vec_active", active, vecs[i].voices);
      idle(2);
    end
    mute = '0;

    // Reset in the middle of playback with ticks in flight.
    do_reset();
    fill_voice(0, 20);
    fill_voice(1, 30);
    cycle(1'b0, 4'b0011);
    for (int i = 0; i < 3; i++) cycle(1'b1, '0);
    check("pre_reset_out", out, 50);
    do_reset();
    cycle(1'b1, '0);
    idle(2);
    check("post_reset_valid", out_valid, 1);
    check("post_reset_out", out, 0);
    idle(2);

`ifdef SAMPLE_MIXER_GAIN_EN
    do_reset();
    fill_voice(0, 64);
    gain = 8'b0000_0010;
    cycle(1'b0, 4'b0001);
    cycle(1'b1, '0);
    idle(2);
    check("gain_out", out, 16);
    idle(2);
    gain = '0;
`endif

    // Randomized traffic: random ROMs, ticks, triggers; mute/gain change only when drained.
    do_reset();
    for (int v = 0; v < NV; v++)
      for (int a = 0; a < LEN; a++) rom[v][a] = DW'($urandom);
    for (int b = 0; b < 8; b++) begin
      mute = NV'($urandom);
`ifdef SAMPLE_MIXER_GAIN_EN
      gain = (2*NV)'($urandom);
`endif
      for (int i = 0; i < 50; i++) begin
        logic          t;
        logic [NV-1:0] tr;
        t  = 1'($urandom_range(1, 0));
        tr = '0;
        if (!t && $urandom_range(5, 0) == 0) tr = NV'($urandom);
        cycle(t, tr);
      end
      idle(4);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
